// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, a one-entry
// skid buffer, and a decode-side output slot with redirect/kill handling.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCSel_bit1,
  input  logic [XLEN-1:0] BTarg,
  input  logic            jal_valid,
  input  logic [XLEN-1:0] JTarg,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [31:0]     instD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc_plus4D,
  output logic            validD,
  input  logic            decode_ready
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT
  } state_e;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  localparam logic [XLEN-1:0] ALGN = ~XLEN'(3);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] infl_q, infl_d;
  logic            kill_q, kill_d;
  logic            skv_q, skv_d;
  logic [31:0]     skinst_q, skinst_d;
  logic [XLEN-1:0] skpc_q, skpc_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            val_q, val_d;

  logic            redirect;
  logic [XLEN-1:0] tgt;
  logic            accept;
  logic            resp_in;
  logic            resp_ok;
  logic            consume;

  assign redirect = PCSel_bit1 | jal_valid;
  assign tgt      = PCSel_bit1 ? BTarg : JTarg;

  assign imem_req_valid = (state_q == S_REQ) & ~skv_q;
  assign imem_req_addr  = pc_q;

  assign accept  = imem_req_valid & imem_req_ready;
  assign resp_in = (state_q == S_WAIT) & imem_resp_valid;
  assign resp_ok = resp_in & ~kill_q & ~redirect;
  assign consume = val_q & decode_ready;

  assign instD     = inst_q;
  assign pcD       = pcd_q;
  assign pc_plus4D = pc4_q;
  assign validD    = val_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    infl_d   = infl_q;
    kill_d   = kill_q;
    skv_d    = skv_q;
    skinst_d = skinst_q;
    skpc_d   = skpc_q;
    inst_d   = inst_q;
    pcd_d    = pcd_q;
    pc4_d    = pc4_q;
    val_d    = val_q;

    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ:  if (accept) state_d = S_WAIT;
      S_WAIT: if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_BOOT;
    endcase

    if (accept) begin
      infl_d = pc_q;
      pc_d   = pc_q + FOUR;
    end
    if (redirect) pc_d = tgt & ALGN;

    // A response landing in the redirect cycle is simply dropped,
    // so kill is only armed for a request still in flight.
    if (resp_in) kill_d = 1'b0;
    if (redirect && (accept || ((state_q == S_WAIT) && !imem_resp_valid)))
      kill_d = 1'b1;

    if (redirect) begin
      val_d  = 1'b0;
      inst_d = NOP_INST;
      skv_d  = 1'b0;
    end else if (resp_ok && (!val_q || consume)) begin
      val_d  = 1'b1;
      inst_d = imem_resp_data;
      pcd_d  = infl_q;
      pc4_d  = infl_q + FOUR;
    end else if (resp_ok) begin
      skv_d    = 1'b1;
      skinst_d = imem_resp_data;
      skpc_d   = infl_q;
    end else if (consume && skv_q) begin
      skv_d  = 1'b0;
      val_d  = 1'b1;
      inst_d = skinst_q;
      pcd_d  = skpc_q;
      pc4_d  = skpc_q + FOUR;
    end else if (consume) begin
      val_d  = 1'b0;
      inst_d = NOP_INST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      infl_q   <= '0;
      kill_q   <= 1'b0;
      skv_q    <= 1'b0;
      skinst_q <= NOP_INST;
      skpc_q   <= '0;
      inst_q   <= NOP_INST;
      pcd_q    <= '0;
      pc4_q    <= FOUR;
      val_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      infl_q   <= infl_d;
      kill_q   <= kill_d;
      skv_q    <= skv_d;
      skinst_q <= skinst_d;
      skpc_q   <= skpc_d;
      inst_q   <= inst_d;
      pcd_q    <= pcd_d;
      pc4_q    <= pc4_d;
      val_q    <= val_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width.
REQ-002 SHALL have parameter RESET_PC, default 32'h4000_0000: first fetch address.
REQ-003 SHALL have parameter NOP_INST, default 32'h0000_0013: instD value when empty.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports, clock and reset first:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- PCSel_bit1  input  1  decode-stage branch taken.
- BTarg  input  XLEN  branch target.
- jal_valid  input  1  decode-stage jump redirect.
- JTarg  input  XLEN  jump target.
- imem_req_valid  output  1  instruction-fetch request.
- imem_req_addr  output  XLEN  fetch address; always equal to pc.
- imem_req_ready  input  1  memory accepts request.
- imem_resp_valid  input  1  single-cycle response pulse.
- imem_resp_data  input  32  fetched instruction.
- instD  output  32  instruction to decode.
- pcD  output  XLEN  PC of instD.
- pc_plus4D  output  XLEN  pcD+4.
- validD  output  1  instD valid.
- decode_ready  input  1  decode consumes the slot when validD && decode_ready.

Function
REQ-005 SHALL keep at most one imem request outstanding.
REQ-006 FSM states SHALL be S_BOOT, S_REQ and S_WAIT; S_BOOT SHALL last exactly one cycle after rst_n deasserts and SHALL go to S_REQ.
REQ-007 In S_REQ, imem_req_valid SHALL be 1 only when the skid buffer is empty.
REQ-008 An accepted request (imem_req_valid && imem_req_ready) SHALL latch inflight_pc <= pc, set pc <= pc+4 (mod 2^XLEN), and move to S_WAIT.
REQ-009 In S_WAIT, imem_resp_valid SHALL return to S_REQ; responses arriving in S_BOOT or S_REQ SHALL be ignored.
REQ-010 Response routing (not killed):
- Output slot empty or consumed that cycle: load instD/pcD=inflight_pc/pc_plus4D=inflight_pc+4 and set validD=1, same edge.
- Otherwise: write the response into the one-entry skid buffer.
REQ-011 When the slot is consumed and the skid buffer is full, the skid buffer SHALL move into the output slot on the same edge.
REQ-012 When the slot is consumed with no refill, validD SHALL go to 0 and instD SHALL be NOP_INST.
REQ-013 While validD=1 && decode_ready=0, instD/pcD/pc_plus4D SHALL hold stable.
REQ-014 Redirect = PCSel_bit1 || jal_valid; PCSel_bit1 SHALL have priority when both are asserted.
REQ-015 On redirect:
- pc <= target with bits[1:0] forced to 0.
- validD <= 0; the skid buffer is cleared.
- In S_WAIT, set kill; if a request is accepted in the redirect cycle, that request is also killed.
REQ-016 A killed response SHALL be dropped and SHALL clear kill; a redirect in the same cycle as that response SHALL still apply.
REQ-017 Redirect latency SHALL be exactly one cycle: the first request to the target is issued the cycle after redirect, unless a kill is pending, in which case it is issued after the killed response.
REQ-018 Fetch-to-decode latency SHALL be one cycle after imem_resp_valid.

Reset
REQ-019 rst_n=0 SHALL immediately force:
- pc=RESET_PC, state=S_BOOT, kill=0, skid empty.
- validD=0, instD=NOP_INST, pcD=0, pc_plus4D=4, imem_req_valid=0.
REQ-020 Reset asserted mid-request SHALL drop any in-flight response without raising validD.

Verification
REQ-021 Reset release, imem_req_ready=1, one-cycle response latency, decode_ready=1 -> addresses 0x4000_0000, 0x4000_0004, 0x4000_0008 in order; pcD follows one cycle after each response.
REQ-022 decode_ready=0 for 5 cycles -> one instruction held in the slot, one in skid, imem_req_valid=0; on decode_ready=1, both delivered in order with no loss.
REQ-023 PCSel_bit1=1, BTarg=0x4000_0100 while in S_WAIT -> the next response is dropped, validD stays 0, the next request address is 0x4000_0100.
REQ-024 PCSel_bit1=1 and jal_valid=1 together (BTarg=0x200, JTarg=0x300) -> next fetch address is 0x200; BTarg=0x203 -> fetch address 0x200.
REQ-025 pc=0xFFFF_FFFC accepted -> next address 0x0000_0000, pc_plus4D=0x0000_0000.
REQ-026 rst_n pulsed low while in S_WAIT, then response arrives in S_BOOT -> response ignored, first request is to RESET_PC.
